// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared state encoding and buffer depth for fifo_drain (FIFO_DRAIN_COUNT_EN enables drain_cnt)
package fifo_drain_pkg;

  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  function automatic logic [1:0] occupancy_of(input state_t s);
    case (s)
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_drain_skid.sv
// rtl/fifo_drain_skid.sv - 2-entry output buffer (head/tail) with registered stream outputs
module fifo_drain_skid
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [WIDTH-1:0] capture_data,
  input  logic             pop,
  output state_t           state,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data
);

  logic [WIDTH-1:0] tail;

  // m_data is the head entry; it only moves on pop or on first fill, so it holds under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EMPTY;
      m_valid <= 1'b0;
      m_data  <= '0;
      tail    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (capture) begin
            m_data  <= capture_data;
            m_valid <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (capture && pop) begin
            m_data <= capture_data;
          end else if (capture) begin
            tail  <= capture_data;
            state <= TWO;
          end else if (pop) begin
            m_valid <= 1'b0;
            state   <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            m_data <= tail;
            if (capture) tail <= capture_data;
            else         state <= ONE;
          end
        end
        default: begin
          m_valid <= 1'b0;
          state   <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - drains a synchronous FIFO into a valid/ready stream; FIFO_DRAIN_COUNT_EN adds drain_cnt
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_DRAIN_COUNT_EN
  ,
  output logic [15:0]      drain_cnt
`endif
);

  state_t     state;
  logic       in_flight;
  logic       pop;
  logic [2:0] pending;

  assign pop = m_valid & m_ready;

  // Credit check: words held plus the word landing next cycle, minus the one leaving now.
  always_comb begin
    pending    = {1'b0, occupancy_of(state)} + {2'b00, in_flight} - {2'b00, pop};
    fifo_rd_en = rst && !fifo_empty && (pending < 3'(BUF_DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in_flight <= 1'b0;
    else      in_flight <= fifo_rd_en;
  end

  fifo_drain_skid #(.WIDTH(WIDTH)) u_skid (
    .clk          (clk),
    .rst          (rst),
    .capture      (in_flight),
    .capture_data (fifo_dout),
    .pop          (pop),
    .state        (state),
    .m_valid      (m_valid),
    .m_data       (m_data)
  );

`ifdef FIFO_DRAIN_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     drain_cnt <= 16'd0;
    else if (pop) drain_cnt <= drain_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// tb/tb_fifo_drain.sv - directed self-checking bench for fifo_drain with a behavioural upstream FIFO
module tb_fifo_drain;

  localparam int MEM_SIZE = 70000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
`ifdef FIFO_DRAIN_COUNT_EN
  logic [15:0] drain_cnt;
`endif

  logic [7:0] mem [MEM_SIZE];
  int         wp = 0;
  int         rp = 0;
  int         compared = 0;
  int         mismatched = 0;

  always #5 clk = ~clk;

  fifo_drain #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_DRAIN_COUNT_EN
    ,
    .drain_cnt  (drain_cnt)
`endif
  );

  // Upstream synchronous FIFO: data appears one cycle after an accepted read.
  always_comb fifo_empty = (rp == wp);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= mem[rp];
      rp        <= rp + 1;
    end
  end

  task automatic push(input logic [7:0] v);
    mem[wp] = v;
    wp = wp + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rx_n;
    logic [7:0] rx [8];
    int base;
    int budget;

    // Reset with words already queued: nothing may be popped while rst is low.
    for (int i = 0; i < 8; i++) push(8'(i));
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(m_valid), 32'd0);
    check("reset_data", 32'(m_data), 32'd0);
    check("reset_rd_en", 32'(fifo_rd_en), 32'd0);
    check("reset_no_read", 32'(rp), 32'd0);
`ifdef FIFO_DRAIN_COUNT_EN
    check("reset_cnt", 32'(drain_cnt), 32'd0);
`endif

    // Streaming: 0..7 on consecutive cycles starting on the second edge.
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("stream_latency", 32'(m_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("stream_valid_%0d", i), 32'(m_valid), 32'd1);
      check($sformatf("stream_data_%0d", i), 32'(m_data), 32'(i));
    end
    tick();
    check("stream_done", 32'(m_valid), 32'd0);
`ifdef FIFO_DRAIN_COUNT_EN
    check("stream_cnt", 32'(drain_cnt), 32'd8);
`endif

    // Backpressure: two words buffered, FIFO reads stop, head held.
    @(negedge clk);
    m_ready = 1'b0;
    base = rp;
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    repeat (5) tick();
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_data_held", 32'(m_data), 32'h10);
    check("bp_rd_en", 32'(fifo_rd_en), 32'd0);
    check("bp_two_read", 32'(rp - base), 32'd2);
    @(negedge clk);
    m_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_order_%0d", i), 32'(m_data), 32'h10 + 32'(i));
      check($sformatf("bp_ovalid_%0d", i), 32'(m_valid), 32'd1);
      tick();
    end
    check("bp_done", 32'(m_valid), 32'd0);

    // Empty FIFO: nothing requested, nothing presented.
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("empty_rd_en_%0d", i), 32'(fifo_rd_en), 32'd0);
      check($sformatf("empty_valid_%0d", i), 32'(m_valid), 32'd0);
    end

    // Toggling ready: every word exactly once, in order.
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(8'd100 + 8'(i));
    rx_n = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      m_ready = (cyc % 2 == 0);
      #1;
      if (m_valid && m_ready) begin
        if (rx_n < 8) rx[rx_n] = m_data;
        rx_n++;
      end
    end
    check("toggle_count", 32'(rx_n), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("toggle_word_%0d", i), 32'(rx[i]), 32'd100 + 32'(i));

    // Mid-stream reset with a read in flight.
    @(negedge clk);
    m_ready = 1'b0;
    push(8'h20);
    push(8'h21);
    tick();
    tick();
    check("mrst_pre_valid", 32'(m_valid), 32'd1);
    check("mrst_pre_data", 32'(m_data), 32'h20);
    #2;
    rst = 1'b0;
    #1;
    check("mrst_async_valid", 32'(m_valid), 32'd0);
    check("mrst_async_data", 32'(m_data), 32'd0);
    check("mrst_async_rd_en", 32'(fifo_rd_en), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_ready = 1'b1;
    repeat (3) tick();
    check("mrst_discard", 32'(m_valid), 32'd0);
`ifdef FIFO_DRAIN_COUNT_EN
    check("mrst_cnt", 32'(drain_cnt), 32'd0);
`endif
    @(negedge clk);
    push(8'hAA);
    tick();
    check("mrst_lat1", 32'(m_valid), 32'd0);
    tick();
    check("mrst_lat2_valid", 32'(m_valid), 32'd1);
    check("mrst_lat2_data", 32'(m_data), 32'hAA);
    tick();
    check("mrst_after", 32'(m_valid), 32'd0);

`ifdef FIFO_DRAIN_COUNT_EN
    // Counter wrap: 65537 pops from a fresh reset leave drain_cnt at 1.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 65537; i++) push(8'(i));
    budget = 0;
    do begin
      tick();
      budget++;
    end while (!(fifo_empty && !m_valid && !dut.in_flight) && budget < 70000);
    check("wrap_in_time", 32'(budget < 70000), 32'd1);
    check("wrap_cnt", 32'(drain_cnt), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
